// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 fetch/decode/execute controller:
// FSM state encoding, instruction field codes, ALU opcodes and the
// immediate-extension helper used by the instruction decoder.
package cr16_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  // Immediate extension select codes
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,   // no immediate, Imm driven as zero
    IMM_SEXT = 2'd1,   // sign-extend imm8
    IMM_ZEXT = 2'd2,   // zero-extend imm8
    IMM_HIGH = 2'd3    // imm8 placed in the upper byte (LUI)
  } imm_sel_t;

  // Primary op field IR[15:12]; 4'h0 selects the register form
  localparam logic [3:0] OP_REG  = 4'h0;
  localparam logic [3:0] OP_ANDI = 4'h1;
  localparam logic [3:0] OP_ORI  = 4'h2;
  localparam logic [3:0] OP_XORI = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h9;
  localparam logic [3:0] OP_CMPI = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hD;
  localparam logic [3:0] OP_LUI  = 4'hF;

  // Extended op field IR[7:4], meaningful only in the register form
  localparam logic [3:0] EXT_NOP = 4'h0;
  localparam logic [3:0] EXT_AND = 4'h1;
  localparam logic [3:0] EXT_OR  = 4'h2;
  localparam logic [3:0] EXT_XOR = 4'h3;
  localparam logic [3:0] EXT_ADD = 4'h5;
  localparam logic [3:0] EXT_SUB = 4'h9;
  localparam logic [3:0] EXT_CMP = 4'hB;
  localparam logic [3:0] EXT_MOV = 4'hD;

  // ALU operation codes presented to RegFile_Alu
  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_AND = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_XOR = 5'd3;
  localparam logic [4:0] ALU_ADD = 5'd4;
  localparam logic [4:0] ALU_SUB = 5'd5;
  localparam logic [4:0] ALU_CMP = 5'd6;
  localparam logic [4:0] ALU_MOV = 5'd7;
  localparam logic [4:0] ALU_LUI = 5'd8;

  // Builds the 16-bit ALU immediate from the 8-bit instruction field
  function automatic logic [15:0] extend_imm(input imm_sel_t sel, input logic [7:0] imm8);
    logic [15:0] v;
    case (sel)
      IMM_SEXT: v = {{8{imm8[7]}}, imm8};
      IMM_ZEXT: v = {8'h00, imm8};
      IMM_HIGH: v = {imm8, 8'h00};
      default:  v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cr16_instr_decoder.sv
// Purely combinational CR16 instruction decoder. Splits the latched
// instruction word into register indices, ALU opcode, extended immediate,
// operand select, register-write intent and an illegal-encoding flag.
module cr16_instr_decoder
  import cr16_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [4:0]  o_opcode,
  output logic [15:0] o_imm,
  output logic        o_imm_s,
  output logic [3:0]  o_rdest,
  output logic [3:0]  o_rsrc,
  output logic        o_wr,
  output logic        o_illegal
);

  logic [3:0] w_op;
  logic [3:0] w_ext;
  imm_sel_t   w_imm_sel;

  assign w_op  = i_ir[15:12];
  assign w_ext = i_ir[7:4];

  // Field decode: register form selects the ALU op from ext, immediate form from op
  always_comb begin
    o_opcode  = ALU_NOP;
    o_imm_s   = 1'b0;
    o_rdest   = i_ir[11:8];
    o_rsrc    = 4'h0;
    o_wr      = 1'b0;
    o_illegal = 1'b0;
    w_imm_sel = IMM_NONE;
    if (w_op == OP_REG) begin
      o_rsrc = i_ir[3:0];
      case (w_ext)
        EXT_NOP: o_opcode = ALU_NOP;
        EXT_AND: begin o_opcode = ALU_AND; o_wr = 1'b1; end
        EXT_OR:  begin o_opcode = ALU_OR;  o_wr = 1'b1; end
        EXT_XOR: begin o_opcode = ALU_XOR; o_wr = 1'b1; end
        EXT_ADD: begin o_opcode = ALU_ADD; o_wr = 1'b1; end
        EXT_SUB: begin o_opcode = ALU_SUB; o_wr = 1'b1; end
        EXT_CMP: o_opcode = ALU_CMP;  // compare only updates flags
        EXT_MOV: begin o_opcode = ALU_MOV; o_wr = 1'b1; end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      o_imm_s = 1'b1;
      case (w_op)
        OP_ANDI: begin o_opcode = ALU_AND; o_wr = 1'b1; w_imm_sel = IMM_ZEXT; end
        OP_ORI:  begin o_opcode = ALU_OR;  o_wr = 1'b1; w_imm_sel = IMM_ZEXT; end
        OP_XORI: begin o_opcode = ALU_XOR; o_wr = 1'b1; w_imm_sel = IMM_ZEXT; end
        OP_ADDI: begin o_opcode = ALU_ADD; o_wr = 1'b1; w_imm_sel = IMM_SEXT; end
        OP_SUBI: begin o_opcode = ALU_SUB; o_wr = 1'b1; w_imm_sel = IMM_SEXT; end
        OP_CMPI: begin o_opcode = ALU_CMP; w_imm_sel = IMM_SEXT; end
        OP_MOVI: begin o_opcode = ALU_MOV; o_wr = 1'b1; w_imm_sel = IMM_ZEXT; end
        OP_LUI:  begin o_opcode = ALU_LUI; o_wr = 1'b1; w_imm_sel = IMM_HIGH; end
        default: o_illegal = 1'b1;
      endcase
    end
  end

  assign o_imm = extend_imm(w_imm_sel, i_ir[7:0]);

endmodule

// File: rtl/cr16_decode_ctrl.sv
// CR16 fetch/decode/execute controller. Owns the program counter, the
// instruction register and the FSM, and presents registered decode fields
// plus the register-file write strobe to RegFile_Alu. With zero-wait
// memory one instruction retires every three cycles. En and the PC
// increment are registered on the edge that leaves EXEC, so En is seen in
// the cycle right after the last EXEC cycle while the fields are still held.
module cr16_decode_ctrl
  import cr16_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
)(
  input  logic            Clk,
  input  logic            Rst,
  input  logic [15:0]     InstrData,
  input  logic            InstrValid,
  input  logic            Stall,
  output logic            InstrReq,
  output logic [PC_W-1:0] PC,
  output logic [3:0]      RdestRegLoc,
  output logic [3:0]      RsrcRegLoc,
  output logic [15:0]     Imm,
  output logic            Imm_s,
  output logic [4:0]      OpCode,
  output logic            En,
  output logic            Illegal
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic            r_run;      // low until the first clock after reset release
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      r_rdest;
  logic [3:0]      r_rsrc;
  logic [15:0]     r_imm;
  logic            r_imm_s;
  logic [4:0]      r_opcode;
  logic            r_wr;       // current instruction writes the register file
  logic            r_en;
  logic            r_illegal;

  logic [4:0]      w_opcode;
  logic [15:0]     w_imm;
  logic            w_imm_s;
  logic [3:0]      w_rdest;
  logic [3:0]      w_rsrc;
  logic            w_wr;
  logic            w_illegal;

  cr16_instr_decoder u_decoder (
    .i_ir      (r_ir),
    .o_opcode  (w_opcode),
    .o_imm     (w_imm),
    .o_imm_s   (w_imm_s),
    .o_rdest   (w_rdest),
    .o_rsrc    (w_rsrc),
    .o_wr      (w_wr),
    .o_illegal (w_illegal)
  );

  // Sequencer: FSM, PC, IR and all registered decode/strobe outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_FETCH;
      r_run     <= 1'b0;
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_rdest   <= 4'h0;
      r_rsrc    <= 4'h0;
      r_imm     <= 16'h0000;
      r_imm_s   <= 1'b0;
      r_opcode  <= ALU_NOP;
      r_wr      <= 1'b0;
      r_en      <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_en      <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // Data is only accepted while the request is actually visible
          if (InstrValid && r_run) begin
            r_ir    <= InstrData;
            r_state <= ST_DECODE;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          r_rdest   <= w_rdest;
          r_rsrc    <= w_rsrc;
          r_imm     <= w_imm;
          r_imm_s   <= w_imm_s;
          r_opcode  <= w_opcode;
          r_wr      <= w_wr;
          r_illegal <= w_illegal;   // single pulse in the first EXEC cycle
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!Stall) begin
            r_en    <= r_wr;
            r_pc    <= r_pc + PC_ONE;
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign InstrReq    = (r_state == ST_FETCH) && r_run;
  assign PC          = r_pc;
  assign RdestRegLoc = r_rdest;
  assign RsrcRegLoc  = r_rsrc;
  assign Imm         = r_imm;
  assign Imm_s       = r_imm_s;
  assign OpCode      = r_opcode;
  assign En          = r_en;
  assign Illegal     = r_illegal;

endmodule

// File: tb/tb_cr16_decode_ctrl.sv
// Scoreboard bench for cr16_decode_ctrl: the driver pushes hand-computed
// expected retirements, a monitor pops them whenever En or Illegal fires.
module tb_cr16_decode_ctrl;

  localparam int         PC_W   = 8;
  localparam logic [7:0] RST_PC = 8'hF0;
  localparam int K_NONE = 0;
  localparam int K_EN   = 1;
  localparam int K_ILL  = 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] InstrData = 16'h0000;
  logic        InstrValid = 1'b0;
  logic        Stall = 1'b0;
  logic        InstrReq;
  logic [7:0]  PC;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [4:0]  OpCode;
  logic        En;
  logic        Illegal;

  cr16_decode_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst(Rst), .InstrData(InstrData), .InstrValid(InstrValid),
    .Stall(Stall), .InstrReq(InstrReq), .PC(PC), .RdestRegLoc(RdestRegLoc),
    .RsrcRegLoc(RsrcRegLoc), .Imm(Imm), .Imm_s(Imm_s), .OpCode(OpCode),
    .En(En), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ill;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        imm_s;
    logic [4:0]  opc;
    logic [7:0]  pc;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    int          kind;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        imm_s;
    logic [4:0]  opc;
    int          dly;
    int          stl;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] pc_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] w, input int kind, input logic [3:0] rd,
                     input logic [3:0] rs, input logic [15:0] imm, input logic imm_s,
                     input logic [4:0] opc, input int dly, input int stl);
    vec_t v;
    v.w = w; v.kind = kind; v.rd = rd; v.rs = rs; v.imm = imm;
    v.imm_s = imm_s; v.opc = opc; v.dly = dly; v.stl = stl;
    vecs.push_back(v);
  endtask

  // Monitor: every En or Illegal pulse must match the oldest expectation
  always @(negedge Clk) begin
    if (!Rst && (En || Illegal)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {30'd0, En, Illegal}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_en", En, !e.ill);
        chk("mon_illegal", Illegal, e.ill);
        chk("mon_pc", PC, e.pc);
        if (!e.ill) begin
          chk("mon_rdest", RdestRegLoc, e.rd);
          chk("mon_rsrc", RsrcRegLoc, e.rs);
          chk("mon_imm", Imm, e.imm);
          chk("mon_imm_s", Imm_s, e.imm_s);
          chk("mon_opcode", OpCode, e.opc);
        end
      end
    end
  end

  // Issues one instruction starting from a FETCH-cycle negedge, ends in the next FETCH
  task automatic issue(input vec_t v);
    exp_t        e;
    logic [3:0]  s_rd;
    logic [3:0]  s_rs;
    logic [15:0] s_imm;
    logic [4:0]  s_op;
    logic        s_is;
    for (int d = 0; d < v.dly; d++) begin
      chk("req_wait", InstrReq, 1'b1);
      @(negedge Clk);
    end
    chk("req_fetch", InstrReq, 1'b1);
    if (v.kind != K_NONE) begin
      e.ill = (v.kind == K_ILL); e.rd = v.rd; e.rs = v.rs; e.imm = v.imm;
      e.imm_s = v.imm_s; e.opc = v.opc;
      e.pc = (v.kind == K_ILL) ? pc_m : pc_m + 8'd1;
      sb.push_back(e);
    end
    InstrData = v.w; InstrValid = 1'b1; Stall = (v.stl > 0);
    @(negedge Clk);
    InstrValid = 1'b0; InstrData = 16'h4FFF;
    chk("req_decode", InstrReq, 1'b0);
    @(negedge Clk);
    chk("illegal_pulse", Illegal, v.kind == K_ILL);
    if (v.stl > 0) begin
      s_rd = RdestRegLoc; s_rs = RsrcRegLoc; s_imm = Imm; s_op = OpCode; s_is = Imm_s;
      for (int k = 0; k < v.stl; k++) begin
        chk("stall_en", En, 1'b0);
        chk("stall_rdest", RdestRegLoc, s_rd);
        chk("stall_rsrc", RsrcRegLoc, s_rs);
        chk("stall_imm", Imm, s_imm);
        chk("stall_opcode", OpCode, s_op);
        chk("stall_imm_s", Imm_s, s_is);
        chk("stall_pc", PC, pc_m);
        if (k == v.stl - 1) Stall = 1'b0;
        @(negedge Clk);
      end
    end else begin
      @(negedge Clk);
    end
    chk("en_timing", En, v.kind == K_EN);
    chk("illegal_clear", Illegal, 1'b0);
    pc_m = pc_m + 8'd1;
    chk("pc_advance", PC, pc_m);
  endtask

  // Asynchronous reset in the middle of a stalled EXEC
  task automatic reset_mid_exec();
    InstrData = 16'h0355; InstrValid = 1'b1; Stall = 1'b1;
    @(negedge Clk);
    InstrValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("midrst_pc", PC, RST_PC);
    chk("midrst_en", En, 1'b0);
    chk("midrst_illegal", Illegal, 1'b0);
    chk("midrst_rdest", RdestRegLoc, 4'h0);
    chk("midrst_req", InstrReq, 1'b0);
    @(negedge Clk);
    Rst = 1'b0; Stall = 1'b0;
    chk("midrst_req_release", InstrReq, 1'b0);
    @(negedge Clk);
    chk("midrst_req_after", InstrReq, 1'b1);
    chk("midrst_no_en", En, 1'b0);
    pc_m = RST_PC;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    //  word      kind    rd    rs    imm       s     opc   dly stl
    add(16'h0355, K_EN,   4'h3, 4'h5, 16'h0000, 1'b0, 5'd4, 0, 0); // ADD R3,R5
    add(16'h52FF, K_EN,   4'h2, 4'h0, 16'hFFFF, 1'b1, 5'd4, 0, 0); // ADDI R2,#-1
    add(16'h12FF, K_EN,   4'h2, 4'h0, 16'h00FF, 1'b1, 5'd1, 0, 0); // ANDI R2,#FF
    add(16'hF112, K_EN,   4'h1, 4'h0, 16'h1200, 1'b1, 5'd8, 0, 0); // LUI R1,#12
    add(16'h0A97, K_EN,   4'hA, 4'h7, 16'h0000, 1'b0, 5'd5, 0, 4); // SUB R10,R7 stalled
    add(16'h2C3C, K_EN,   4'hC, 4'h0, 16'h003C, 1'b1, 5'd2, 5, 0); // ORI late valid
    add(16'h0000, K_NONE, 4'h0, 4'h0, 16'h0000, 1'b0, 5'd0, 0, 0); // NOP
    add(16'h4123, K_ILL,  4'h1, 4'h0, 16'h0000, 1'b0, 5'd0, 0, 0); // unmapped op
    add(16'h0164, K_ILL,  4'h1, 4'h4, 16'h0000, 1'b0, 5'd0, 0, 0); // unmapped ext
    add(16'hB480, K_NONE, 4'h4, 4'h0, 16'hFF80, 1'b1, 5'd6, 0, 0); // CMPI
    add(16'h9380, K_EN,   4'h3, 4'h0, 16'hFF80, 1'b1, 5'd5, 0, 0); // SUBI R3,#-128
    add(16'h3E81, K_EN,   4'hE, 4'h0, 16'h0081, 1'b1, 5'd3, 0, 0); // XORI
    add(16'hD77F, K_EN,   4'h7, 4'h0, 16'h007F, 1'b1, 5'd7, 0, 0); // MOVI
    add(16'h0BD2, K_EN,   4'hB, 4'h2, 16'h0000, 1'b0, 5'd7, 0, 0); // MOV R11,R2
    add(16'h01B2, K_NONE, 4'h1, 4'h2, 16'h0000, 1'b0, 5'd6, 0, 0); // CMP
    add(16'h0610, K_EN,   4'h6, 4'h0, 16'h0000, 1'b0, 5'd1, 0, 0); // AND R6,R0
    add(16'h0F3E, K_EN,   4'hF, 4'hE, 16'h0000, 1'b0, 5'd3, 0, 2); // XOR, retires past wrap

    repeat (2) @(negedge Clk);
    chk("rst_pc", PC, RST_PC);
    chk("rst_en", En, 1'b0);
    chk("rst_illegal", Illegal, 1'b0);
    chk("rst_req", InstrReq, 1'b0);
    chk("rst_imm", Imm, 16'h0000);
    chk("rst_opcode", OpCode, 5'd0);
    Rst = 1'b0;
    chk("rel_req", InstrReq, 1'b0);
    @(negedge Clk);
    chk("first_req", InstrReq, 1'b1);
    pc_m = RST_PC;

    reset_mid_exec();

    foreach (vecs[i]) issue(vecs[i]);

    chk("pc_wrapped", PC, 8'h01);
    repeat (3) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
